// File: rtl/top_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : top_seq_pkg
// Brief    : Shared defaults, state encoding and width helper for the sweep
//            sequencer.
// Revision : 1.0
// ============================================================================
package top_seq_pkg;

   localparam int DEF_W      = 4;
   localparam int DEF_SETTLE = 2;
   localparam int DEF_SUM_W  = 8;

   // Counter must hold SETTLE-1; keep at least one bit so SETTLE==0 still elaborates.
   function automatic int cnt_width(input int settle);
      return (settle < 1) ? 1 : $clog2(settle + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEF_SETTLE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_APPLY  = 3'd2,
      S_WAIT   = 3'd3,
      S_SAMPLE = 3'd4,
      S_FIN    = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/top_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : top_sequencer_if
// Brief    : Command, datapath and result signals of the sweep sequencer.
// Revision : 1.0
// ============================================================================
interface top_sequencer_if
   import top_seq_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int SUM_W = DEF_SUM_W
) ();

   logic             start;
   logic             abort;
   logic [W-1:0]     x_first;
   logic [W-1:0]     x_last;
   logic             busy;
   logic             done;
   logic             dp_reset;
   logic             dp_enable;
   logic [W-1:0]     dp_x;
   logic [W-1:0]     dp_y;
   logic             res_valid;
   logic [W-1:0]     res_x;
   logic [W-1:0]     res_y;
   logic [SUM_W-1:0] sum;

   modport slave (
      input  start, abort, x_first, x_last, dp_y,
      output busy, done, dp_reset, dp_enable, dp_x, res_valid, res_x, res_y, sum
   );

   modport master (
      output start, abort, x_first, x_last, dp_y,
      input  busy, done, dp_reset, dp_enable, dp_x, res_valid, res_x, res_y, sum
   );

endinterface
`default_nettype wire

// File: rtl/top_seq_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : top_seq_settle_cnt
// Brief    : Loadable down-counter timing the settle interval; stops at zero.
// Revision : 1.0
// ============================================================================
module top_seq_settle_cnt #(
   parameter int CNT_W = 1
) (
   input  wire             clk,
   input  wire             reset,
   input  wire             clear,
   input  wire             load,
   input  wire [CNT_W-1:0] load_val,
   input  wire             en,
   output logic            zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/top_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : top_sequencer
// Brief    : Sweeps the datapath input from x_first to x_last, sampling y
//            after a settle delay and accumulating a checksum.
// Revision : 1.0
// ============================================================================
module top_sequencer
   import top_seq_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int SETTLE = DEF_SETTLE,
   parameter int SUM_W  = DEF_SUM_W
) (
   input  wire            clk,
   input  wire            reset,
   top_sequencer_if.slave bus
);

   localparam int              CNT_WIDTH = cnt_width(SETTLE);
   localparam [CNT_WIDTH-1:0]  C_LOAD    = CNT_WIDTH'((SETTLE > 0) ? SETTLE - 1 : 0);

   seq_state_t       r_state;
   seq_state_t       w_next;
   logic [W-1:0]     r_code;
   logic [W-1:0]     r_last;
   logic [SUM_W-1:0] r_sum;
   logic [W-1:0]     r_res_x;
   logic [W-1:0]     r_res_y;
   logic             r_res_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_dp_reset;
   logic             r_dp_enable;
   logic             w_accept;
   logic             w_cnt_load;
   logic             w_cnt_en;
   logic             w_cnt_zero;
   logic             w_next_active;

   assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;

   top_seq_settle_cnt #(.CNT_W(CNT_WIDTH)) u_settle (
      .clk      (clk),
      .reset    (reset),
      .clear    (bus.abort),
      .load     (w_cnt_load),
      .load_val (C_LOAD),
      .en       (w_cnt_en),
      .zero     (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_load = 1'b0;
      w_cnt_en   = 1'b0;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_INIT;
         S_INIT:   w_next = S_APPLY;
         S_APPLY: begin
            w_cnt_load = 1'b1;
            w_next     = (SETTLE == 0) ? S_SAMPLE : S_WAIT;
         end
         S_WAIT: begin
            w_cnt_en = 1'b1;
            if (w_cnt_zero) w_next = S_SAMPLE;
         end
         S_SAMPLE: w_next = (r_code == r_last) ? S_FIN : S_APPLY;
         S_FIN:    w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (bus.abort && (r_state != S_IDLE)) w_next = S_IDLE;
   end

   assign w_next_active = (w_next == S_APPLY) || (w_next == S_WAIT) || (w_next == S_SAMPLE);

   // Control outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_dp_reset  <= 1'b1;
         r_dp_enable <= 1'b0;
      end else begin
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (w_next == S_FIN);
         r_dp_reset  <= !w_next_active;
         r_dp_enable <= w_next_active;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_code      <= '0;
         r_last      <= '0;
         r_sum       <= '0;
         r_res_x     <= '0;
         r_res_y     <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= (r_state == S_SAMPLE);
         if (w_accept) begin
            r_code <= bus.x_first;
            r_last <= bus.x_last;
            r_sum  <= '0;
         end
         if (r_state == S_SAMPLE) begin
            r_res_x <= r_code;
            r_res_y <= bus.dp_y;
            r_sum   <= r_sum + SUM_W'(bus.dp_y);
            if (r_code != r_last) r_code <= r_code + W'(1);
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.dp_reset  = r_dp_reset;
   assign bus.dp_enable = r_dp_enable;
   assign bus.dp_x      = r_code;
   assign bus.res_valid = r_res_valid;
   assign bus.res_x     = r_res_x;
   assign bus.res_y     = r_res_y;
   assign bus.sum       = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_top_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_sequencer
// Brief    : Directed sweeps of top_sequencer against a cycle-timeline model.
// Revision : 1.0
// ============================================================================
module tb_top_sequencer;

   localparam int W     = 4;
   localparam int SUM_W = 8;
   localparam int S     = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic inv   = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   top_sequencer_if #(.W(W), .SUM_W(SUM_W)) bus  ();
   top_sequencer_if #(.W(W), .SUM_W(SUM_W)) bus0 ();

   // Stand-in datapath: identity, or bitwise inverse when inv is set.
   assign bus.dp_y  = inv ? ~bus.dp_x : bus.dp_x;
   assign bus0.dp_y = bus0.dp_x;

   top_sequencer #(.W(W), .SETTLE(S), .SUM_W(SUM_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   top_sequencer #(.W(W), .SETTLE(0), .SUM_W(SUM_W)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] f_y(input logic [W-1:0] x);
      return inv ? ~x : x;
   endfunction

   // Model: t counts cycles from the one carrying the accepted start (t=0).
   bit           m_active = 1'b0;
   int           m_t      = 0;
   logic [W-1:0] m_xf     = '0;
   logic [W-1:0] m_xl     = '0;

   task automatic model_check(input int t);
      logic [W-1:0]     d;
      logic [W-1:0]     ex;
      logic [SUM_W-1:0] es;
      int steps, per, tot, c;
      bit en, rv;
      d     = m_xl - m_xf;
      steps = int'(d) + 1;
      per   = S + 2;
      tot   = 2 + steps * per;
      if (t > tot) begin
         chk("after_busy", bus.busy, 0);
         chk("after_done", bus.done, 0);
         m_active = 1'b0;
         return;
      end
      en = (t >= 2) && (t <= tot - 1);
      rv = (t > 2) && (((t - 2) % per) == 0);
      c  = (t < 2) ? 0 : (t - 2) / per;
      es = '0;
      for (int i = 0; i < c; i++) es = es + SUM_W'(f_y(m_xf + W'(i)));
      chk("busy", bus.busy, 1);
      chk("done", bus.done, (t == tot) ? 1 : 0);
      chk("dp_enable", bus.dp_enable, en);
      chk("dp_reset", bus.dp_reset, !en);
      chk("res_valid", bus.res_valid, rv);
      chk("sum", bus.sum, es);
      if (t == 1) chk("dp_x_init", bus.dp_x, m_xf);
      if (en) begin
         ex = m_xf + W'((t - 2) / per);
         chk("dp_x", bus.dp_x, ex);
      end
      if (rv) begin
         ex = m_xf + W'(c - 1);
         chk("res_x", bus.res_x, ex);
         chk("res_y", bus.res_y, f_y(ex));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (m_active) begin
            m_t = m_t + 1;
            if (m_t >= 1) model_check(m_t);
         end
      end
   end

   logic [2*W-1:0] q  [$];
   logic [W-1:0]   q0 [$];

   always @(negedge clk) begin
      if (bus.res_valid === 1'b1)  q.push_back({bus.res_x, bus.res_y});
      if (bus0.res_valid === 1'b1) q0.push_back(bus0.res_x);
   end

   task automatic do_start(input logic [W-1:0] xf, input logic [W-1:0] xl);
      bus.x_first = xf;
      bus.x_last  = xl;
      bus.start   = 1'b1;
      m_xf        = xf;
      m_xl        = xl;
      m_t         = -1;
      m_active    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int exp_n, input string name);
      int n;
      n = n0;
      while ((bus.done !== 1'b1) && (n < 300)) begin
         @(negedge clk);
         n++;
      end
      chk(name, n, exp_n);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},      bus.busy, 0);
      chk({tag, "_done"},      bus.done, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_dp_reset"},  bus.dp_reset, 1);
      chk({tag, "_dp_enable"}, bus.dp_enable, 0);
      chk({tag, "_dp_x"},      bus.dp_x, 0);
      chk({tag, "_res_x"},     bus.res_x, 0);
      chk({tag, "_res_y"},     bus.res_y, 0);
      chk({tag, "_sum"},       bus.sum, 0);
   endtask

   initial begin
      logic [2*W-1:0] e;
      logic [W-1:0]   exp_x [4];
      bit seen;
      int n;

      bus.start  = 1'b0; bus.abort  = 1'b0; bus.x_first  = '0; bus.x_last  = '0;
      bus0.start = 1'b0; bus0.abort = 1'b0; bus0.x_first = '0; bus0.x_last = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("por");
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("por_idle");

      // 0..7 identity: 8 steps, sum 28, done at start+34
      q.delete();
      do_start(4'd0, 4'd7);
      wait_done(1, 34, "done_lat_0_7");
      chk("sum_0_7", bus.sum, 28);
      repeat (2) @(negedge clk);
      chk("nres_0_7", q.size(), 8);
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         e = {W'(i), W'(i)};
         chk("res_0_7", q[i], e);
      end

      // Wrapping sweep 14..1
      q.delete();
      do_start(4'd14, 4'd1);
      wait_done(1, 18, "done_lat_14_1");
      chk("sum_14_1", bus.sum, 30);
      repeat (2) @(negedge clk);
      chk("nres_14_1", q.size(), 4);
      exp_x = '{4'd14, 4'd15, 4'd0, 4'd1};
      for (int i = 0; i < 4 && i < q.size(); i++) begin
         e = q[i];
         chk("res_x_14_1", e[2*W-1:W], exp_x[i]);
      end

      // Full 16-step sweep through an inverting datapath
      inv = 1'b1;
      q.delete();
      do_start(4'd10, 4'd9);
      wait_done(1, 66, "done_lat_full");
      chk("sum_full_inv", bus.sum, 120);
      repeat (2) @(negedge clk);
      chk("nres_full", q.size(), 16);
      inv = 1'b0;

      // Abort during the third WAIT of 0..7
      q.delete();
      do_start(4'd0, 4'd7);
      repeat (10) @(negedge clk);
      bus.abort = 1'b1;
      m_active  = 1'b0;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_dp_enable", bus.dp_enable, 0);
      chk("abort_dp_reset", bus.dp_reset, 1);
      chk("abort_sum", bus.sum, 1);
      seen = 1'b0;
      repeat (40) begin
         if (bus.done === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_done", seen, 0);
      chk("abort_sum_held", bus.sum, 1);
      chk("abort_nres", q.size(), 2);

      do_start(4'd2, 4'd4);
      wait_done(1, 14, "done_lat_after_abort");
      chk("sum_after_abort", bus.sum, 9);
      repeat (2) @(negedge clk);

      // Start while busy with different parameters is ignored
      do_start(4'd0, 4'd3);
      repeat (4) @(negedge clk);
      bus.x_first = 4'd9;
      bus.x_last  = 4'd12;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(6, 18, "done_lat_busy_start");
      chk("sum_busy_start", bus.sum, 6);
      repeat (2) @(negedge clk);

      // start with abort in IDLE: stays idle, sum untouched
      bus.x_first = 4'd3;
      bus.x_last  = 4'd5;
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) begin
         chk("start_abort_busy", bus.busy, 0);
         chk("start_abort_dp_reset", bus.dp_reset, 1);
         @(negedge clk);
      end
      chk("start_abort_sum", bus.sum, 6);

      // Reset pulse mid-sweep
      do_start(4'd3, 4'd7);
      repeat (6) @(negedge clk);
      reset    = 1'b0;
      m_active = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk_reset_vals("midrst");
      do_start(4'd1, 4'd2);
      wait_done(1, 10, "done_lat_after_reset");
      chk("sum_after_reset", bus.sum, 3);
      repeat (2) @(negedge clk);

      // SETTLE=0 instance, single step
      q0.delete();
      bus0.x_first = 4'd5;
      bus0.x_last  = 4'd5;
      bus0.start   = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      n = 1;
      while ((bus0.done !== 1'b1) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      chk("s0_done_lat", n, 4);
      repeat (2) @(negedge clk);
      chk("s0_nres", q0.size(), 1);
      if (q0.size() > 0) chk("s0_res_x", q0[0], 5);
      chk("s0_sum", bus0.sum, 5);
      chk("s0_busy_after", bus0.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
